// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 scan-code set 2 decoder.
//   state_t       decoder FSM states
//   PFX_*         extended / break / pause prefix bytes
//   STATUS_BYTES  keyboard status/acknowledge bytes recognised in IDLE
//   PAUSE_SEQ     full Pause sequence; index 0 is the leading E1
//   ps2_event_t   key event {ext, brk, code}
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EXT,
      ST_BRK,
      ST_EXT_BRK,
      ST_PAUSE
   } state_t;

   localparam logic [7:0] PFX_E0 = 8'hE0;
   localparam logic [7:0] PFX_F0 = 8'hF0;
   localparam logic [7:0] PFX_E1 = 8'hE1;

   localparam int NUM_STATUS = 7;
   localparam logic [7:0] STATUS_BYTES [NUM_STATUS] =
      '{8'hAA, 8'hFC, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};

   localparam logic [7:0] PAUSE_SEQ [8] =
      '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } ps2_event_t;

   function automatic logic is_status(input logic [7:0] b);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < NUM_STATUS; i++)
         if (b == STATUS_BYTES[i]) hit = 1'b1;
      return hit;
   endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: synchronous event FIFO, DEPTH entries (power of two, >= 2).
//   sysclk, reset  clock, async active-high reset
//   push, din      write request and data; accepted when not full or when
//                  popping in the same cycle
//   pop            read request; ignored while empty
//   full, empty    status
//   head           entry at the read pointer
module ps2_event_fifo
   import ps2_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       sysclk,
   input  logic       reset,
   input  logic       push,
   input  ps2_event_t din,
   input  logic       pop,
   output logic       full,
   output logic       empty,
   output ps2_event_t head
);

   localparam int AW = $clog2(DEPTH);

   // Pointers carry one extra wrap bit to tell full from empty.
   logic [AW:0] wr_ptr, rd_ptr;
   ps2_event_t  mem [DEPTH];
   logic        do_push, do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: parses scan-code set 2 bytes into key events.
//   sysclk, reset        clock, async active-high reset
//   in_word, in_done     received byte and its one-cycle strobe
//   ev_valid/ev_ready    head-of-FIFO handshake; ev_code/ev_ext/ev_brk = head
//   status_valid/_code   pulse + held value for keyboard status bytes
//   proto_err            pulse on aborted sequence (timeout, Pause mismatch)
//   overflow             sticky: an event was dropped on a full FIFO
module ps2_scancode_decoder
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic       sysclk,
   input  logic       reset,
   input  logic [7:0] in_word,
   input  logic       in_done,
   output logic       ev_valid,
   input  logic       ev_ready,
   output logic [7:0] ev_code,
   output logic       ev_ext,
   output logic       ev_brk,
   output logic       status_valid,
   output logic [7:0] status_code,
   output logic       proto_err,
   output logic       overflow
);

   localparam int         TW    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

   state_t        state;
   logic [2:0]    pidx;
   logic [TW-1:0] tcnt;
   logic          push, full, empty;
   ps2_event_t    push_ev, head;

   // Completing byte is written into the FIFO on the same edge that
   // samples it, so the event is visible one cycle after in_done.
   always_comb begin
      push    = 1'b0;
      push_ev = '{ext: 1'b0, brk: 1'b0, code: in_word};
      if (in_done) begin
         case (state)
            ST_IDLE: push = (in_word != PFX_E0) && (in_word != PFX_F0) &&
                            (in_word != PFX_E1) && !is_status(in_word);
            ST_EXT: begin
               push        = (in_word != PFX_F0);
               push_ev.ext = 1'b1;
            end
            ST_BRK: begin
               push        = 1'b1;
               push_ev.brk = 1'b1;
            end
            ST_EXT_BRK: begin
               push        = 1'b1;
               push_ev.ext = 1'b1;
               push_ev.brk = 1'b1;
            end
            ST_PAUSE: begin
               push         = (in_word == PAUSE_SEQ[pidx]) && (pidx == 3'd7);
               push_ev.ext  = 1'b1;
               push_ev.code = PFX_E1;
            end
            default: push = 1'b0;
         endcase
      end
   end

   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         pidx         <= '0;
         tcnt         <= '0;
         status_valid <= 1'b0;
         status_code  <= '0;
         proto_err    <= 1'b0;
         overflow     <= 1'b0;
      end else begin
         status_valid <= 1'b0;
         proto_err    <= 1'b0;
         // full implies non-empty, so ev_ready alone means a pop frees a slot
         if (push && full && !ev_ready) overflow <= 1'b1;
         if (in_done) begin
            tcnt <= '0;
            case (state)
               ST_IDLE: begin
                  if (in_word == PFX_E0)      state <= ST_EXT;
                  else if (in_word == PFX_F0) state <= ST_BRK;
                  else if (in_word == PFX_E1) begin
                     state <= ST_PAUSE;
                     pidx  <= 3'd1;
                  end else if (is_status(in_word)) begin
                     status_valid <= 1'b1;
                     status_code  <= in_word;
                  end
               end
               ST_EXT:  state <= (in_word == PFX_F0) ? ST_EXT_BRK : ST_IDLE;
               ST_PAUSE: begin
                  if (in_word == PAUSE_SEQ[pidx]) begin
                     if (pidx == 3'd7) state <= ST_IDLE;
                     else              pidx  <= pidx + 3'd1;
                  end else begin
                     // mismatching byte is dropped, not re-parsed
                     proto_err <= 1'b1;
                     state     <= ST_IDLE;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end else if (state != ST_IDLE) begin
            if (tcnt == TLAST) begin
               proto_err <= 1'b1;
               state     <= ST_IDLE;
               tcnt      <= '0;
            end else begin
               tcnt <= tcnt + 1'b1;
            end
         end
      end
   end

   ps2_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .sysclk (sysclk),
      .reset  (reset),
      .push   (push),
      .din    (push_ev),
      .pop    (ev_ready),
      .full   (full),
      .empty  (empty),
      .head   (head)
   );

   assign ev_valid = !empty;
   assign ev_code  = head.code;
   assign ev_ext   = head.ext;
   assign ev_brk   = head.brk;

endmodule
